// File: rtl/nf10_rbs_reg_node_if.sv
// rtl/nf10_rbs_reg_node_if.sv - RBS ring segment: the six fields carried between ring nodes
interface nf10_rbs_reg_node_if #(
    parameter int SRC_WIDTH = 2
);
    logic                 req;
    logic                 ack;
    logic                 rd_wr_l;
    logic [29:0]          addr;
    logic [31:0]          data;
    logic [SRC_WIDTH-1:0] src;

    modport master (output req, ack, rd_wr_l, addr, data, src);
    modport slave  (input  req, ack, rd_wr_l, addr, data, src);
endinterface

// File: rtl/nf10_rbs_reg_node.sv
// rtl/nf10_rbs_reg_node.sv - RBS ring slave node with RW control and RO status registers
module nf10_rbs_reg_node #(
    parameter logic [29:0] C_BASE_WADDR    = 30'h1DB00000,
    parameter int          C_OFFSET_BITS   = 4,
    parameter int          C_NUM_RW_REGS   = 4,
    parameter int          C_NUM_RO_REGS   = 4,
    parameter logic [31:0] C_RW_RESET_VAL  = 32'h0,
    parameter int          C_RBS_SRC_WIDTH = 2
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    nf10_rbs_reg_node_if.slave           s_rbs,
    nf10_rbs_reg_node_if.master          m_rbs,
    output logic [32*C_NUM_RW_REGS-1:0]  RW_REGS,
    output logic [C_NUM_RW_REGS-1:0]     RW_WR_STB,
    input  logic [32*C_NUM_RO_REGS-1:0]  RO_REGS,
    output logic [C_NUM_RO_REGS-1:0]     RO_RD_STB
);

    if ((C_NUM_RW_REGS + C_NUM_RO_REGS) > (2 ** C_OFFSET_BITS)) begin : g_bad_cfg
        $error("nf10_rbs_reg_node: register bank does not fit in the address window");
    end

    logic                       req_q, ack_q, rd_wr_l_q;
    logic [29:0]                addr_q;
    logic [31:0]                data_q;
    logic [C_RBS_SRC_WIDTH-1:0] src_q;
    logic [31:0]                rw_q [C_NUM_RW_REGS];
    logic [C_NUM_RW_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [C_NUM_RO_REGS-1:0]   rd_stb_q, rd_stb_d;
    logic                       ack_d;
    logic [31:0]                data_d;
    logic                       hit;
    logic [31:0]                off_w;

    assign hit   = s_rbs.req & ~s_rbs.ack &
                   (s_rbs.addr[29:C_OFFSET_BITS] == C_BASE_WADDR[29:C_OFFSET_BITS]);
    assign off_w = 32'(s_rbs.addr[C_OFFSET_BITS-1:0]);

    // Only ACK and DATA can change on a hit; everything else rides through untouched.
    always_comb begin
        ack_d    = s_rbs.ack;
        data_d   = s_rbs.data;
        wr_stb_d = '0;
        rd_stb_d = '0;
        if (hit) begin
            ack_d = 1'b1;
            if (s_rbs.rd_wr_l) begin
                data_d = 32'hDEADBEEF;
                for (int k = 0; k < C_NUM_RW_REGS; k++) begin
                    if (off_w == 32'(k)) data_d = rw_q[k];
                end
                for (int k = 0; k < C_NUM_RO_REGS; k++) begin
                    if (off_w == 32'(C_NUM_RW_REGS + k)) begin
                        data_d      = RO_REGS[32*k +: 32];
                        rd_stb_d[k] = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < C_NUM_RW_REGS; k++) begin
                    if (off_w == 32'(k)) wr_stb_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            rd_wr_l_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            src_q     <= '0;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            for (int k = 0; k < C_NUM_RW_REGS; k++) rw_q[k] <= C_RW_RESET_VAL;
        end else begin
            req_q     <= s_rbs.req;
            ack_q     <= ack_d;
            rd_wr_l_q <= s_rbs.rd_wr_l;
            addr_q    <= s_rbs.addr;
            data_q    <= data_d;
            src_q     <= s_rbs.src;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            for (int k = 0; k < C_NUM_RW_REGS; k++) begin
                if (wr_stb_d[k]) rw_q[k] <= s_rbs.data;
            end
        end
    end

    assign m_rbs.req     = req_q;
    assign m_rbs.ack     = ack_q;
    assign m_rbs.rd_wr_l = rd_wr_l_q;
    assign m_rbs.addr    = addr_q;
    assign m_rbs.data    = data_q;
    assign m_rbs.src     = src_q;
    assign RW_WR_STB     = wr_stb_q;
    assign RO_RD_STB     = rd_stb_q;

    for (genvar k = 0; k < C_NUM_RW_REGS; k++) begin : g_rw_out
        assign RW_REGS[32*k +: 32] = rw_q[k];
    end

endmodule

// File: tb/tb_nf10_rbs_reg_node.sv
// tb/tb_nf10_rbs_reg_node.sv - scoreboard bench for nf10_rbs_reg_node
module tb_nf10_rbs_reg_node;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] rw_regs;
    logic [3:0]   rw_wr_stb;
    logic [127:0] ro_regs = {32'h0F0F0F0F, 32'hC3C3C3C3, 32'h12345678, 32'hA0A0A0A0};
    logic [3:0]   ro_rd_stb;

    int n_checks = 0;
    int n_err    = 0;

    nf10_rbs_reg_node_if #(.SRC_WIDTH(2)) s_rbs ();
    nf10_rbs_reg_node_if #(.SRC_WIDTH(2)) m_rbs ();

    nf10_rbs_reg_node dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_rbs         (s_rbs),
        .m_rbs         (m_rbs),
        .RW_REGS       (rw_regs),
        .RW_WR_STB     (rw_wr_stb),
        .RO_REGS       (ro_regs),
        .RO_RD_STB     (ro_rd_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [66:0]  fields;
        logic [3:0]   wstb;
        logic [3:0]   rstb;
        logic [127:0] rw;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] shadow = '0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [66:0] out_fields();
        return {m_rbs.req, m_rbs.ack, m_rbs.rd_wr_l, m_rbs.addr, m_rbs.data, m_rbs.src};
    endfunction

    task automatic drive(input bit req, input bit ack, input bit rd, input logic [29:0] addr,
                         input logic [31:0] data, input logic [1:0] src);
        s_rbs.req = req; s_rbs.ack = ack; s_rbs.rd_wr_l = rd;
        s_rbs.addr = addr; s_rbs.data = data; s_rbs.src = src;
    endtask

    // One ring slot per call; the expected output one cycle later is queued for the monitor.
    task automatic xact(input string nm, input bit req, input bit ack, input bit rd,
                        input logic [29:0] addr, input logic [31:0] data, input logic [1:0] src,
                        input bit e_ack, input logic [31:0] e_data,
                        input logic [3:0] e_w, input logic [3:0] e_r);
        exp_t e;
        @(posedge clk);
        #1;
        drive(req, ack, rd, addr, data, src);
        for (int k = 0; k < 4; k++) if (e_w[k]) shadow[32*k +: 32] = data;
        e.name   = nm;
        e.fields = {req, e_ack, rd, addr, e_data, src};
        e.wstb   = e_w;
        e.rstb   = e_r;
        e.rw     = shadow;
        exp_q.push_back(e);
    endtask

    task automatic idle_and_drain(input string nm);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check({nm, "_drain"}, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (m_rbs.req || m_rbs.ack)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(out_fields()), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_fields"}, 128'(out_fields()), 128'(e.fields));
                    check({e.name, "_wr_stb"}, 128'(rw_wr_stb), 128'(e.wstb));
                    check({e.name, "_rd_stb"}, 128'(ro_rd_stb), 128'(e.rstb));
                    check({e.name, "_rw_regs"}, rw_regs, e.rw);
                end
            end else if (rst_n) begin
                check("idle_strobes", 128'({rw_wr_stb, ro_rd_stb}), 128'd0);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00);
        #2;
        check("reset_fields", 128'(out_fields()), 128'd0);
        check("reset_rw_regs", rw_regs, 128'd0);
        check("reset_strobes", 128'({rw_wr_stb, ro_rd_stb}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        xact("wr_reg1",   1, 0, 0, 30'h1DB00001, 32'hF00DFACE, 2'd2, 1, 32'hF00DFACE, 4'b0010, 4'b0000);
        xact("rd_ro1",    1, 0, 1, 30'h1DB00005, 32'h00000000, 2'd1, 1, 32'h12345678, 4'b0000, 4'b0010);
        xact("rd_reg1",   1, 0, 1, 30'h1DB00001, 32'h00000000, 2'd0, 1, 32'hF00DFACE, 4'b0000, 4'b0000);
        xact("rd_off_a",  1, 0, 1, 30'h1DB0000A, 32'h00000000, 2'd3, 1, 32'hDEADBEEF, 4'b0000, 4'b0000);
        xact("wr_off_6",  1, 0, 0, 30'h1DB00006, 32'h55555555, 2'd1, 1, 32'h55555555, 4'b0000, 4'b0000);
        xact("wr_off_f",  1, 0, 0, 30'h1DB0000F, 32'h66666666, 2'd2, 1, 32'h66666666, 4'b0000, 4'b0000);
        xact("miss_wr",   1, 0, 0, 30'h1DB10000, 32'h11112222, 2'd3, 0, 32'h11112222, 4'b0000, 4'b0000);
        xact("miss_rd",   1, 0, 1, 30'h1DB00013, 32'h33334444, 2'd1, 0, 32'h33334444, 4'b0000, 4'b0000);
        xact("preacked",  1, 1, 1, 30'h1DB00002, 32'hCAFEBABE, 2'd2, 1, 32'hCAFEBABE, 4'b0000, 4'b0000);
        xact("noreq_ack", 0, 1, 0, 30'h1DB00000, 32'h99998888, 2'd1, 1, 32'h99998888, 4'b0000, 4'b0000);
        xact("b2b_wr2",   1, 0, 0, 30'h1DB00002, 32'h0BADF00D, 2'd0, 1, 32'h0BADF00D, 4'b0100, 4'b0000);
        xact("b2b_rd2",   1, 0, 1, 30'h1DB00002, 32'h00000000, 2'd0, 1, 32'h0BADF00D, 4'b0000, 4'b0000);
        xact("wr_reg0",   1, 0, 0, 30'h1DB00000, 32'h01020304, 2'd1, 1, 32'h01020304, 4'b0001, 4'b0000);
        xact("wr_reg3",   1, 0, 0, 30'h1DB00003, 32'h89ABCDEF, 2'd2, 1, 32'h89ABCDEF, 4'b1000, 4'b0000);
        xact("rd_reg0",   1, 0, 1, 30'h1DB00000, 32'hFFFFFFFF, 2'd3, 1, 32'h01020304, 4'b0000, 4'b0000);
        xact("rd_ro3",    1, 0, 1, 30'h1DB00007, 32'h00000000, 2'd0, 1, 32'h0F0F0F0F, 4'b0000, 4'b1000);
        xact("rd_ro0",    1, 0, 1, 30'h1DB00004, 32'h00000000, 2'd1, 1, 32'hA0A0A0A0, 4'b0000, 4'b0001);
        xact("rd_off_8",  1, 0, 1, 30'h1DB00008, 32'h00000000, 2'd2, 1, 32'hDEADBEEF, 4'b0000, 4'b0000);
        idle_and_drain("main");

        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 30'h1DB00000, 32'h77777777, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_fields", 128'(out_fields()), 128'd0);
        check("midrst_rw_regs", rw_regs, 128'd0);
        check("midrst_strobes", 128'({rw_wr_stb, ro_rd_stb}), 128'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        shadow = '0;
        @(negedge clk);
        check("postrst_fields", 128'(out_fields()), 128'd0);
        check("postrst_rw_regs", rw_regs, 128'd0);

        xact("rst_rd1",   1, 0, 1, 30'h1DB00001, 32'h00000000, 2'd1, 1, 32'h00000000, 4'b0000, 4'b0000);
        xact("rst_wr0",   1, 0, 0, 30'h1DB00000, 32'h13572468, 2'd3, 1, 32'h13572468, 4'b0001, 4'b0000);
        idle_and_drain("post");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
